rns_poly_subtractor: RTL and testbench

Streaming modular subtractor for RNS polynomials: computes out = (a - b) mod q_j for every residue j of every coefficient. It is the inverse operation of the combinational RNS polynomial adder, and is used for ciphertext subtraction and key-switch correction terms. Unlike the adder, it accepts one coefficient per beat over a valid/ready stream and runs through a 2-stage pipeline with full backpressure. It tracks polynomial framing, so downstream blocks receive a last marker per polynomial.

---
 rtl/rns_poly_subtractor.sv | 133 +++++++++++++
 tb/tb_rns_poly_subtractor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rns_poly_subtractor.sv
// Streaming RNS modular subtractor: out_j = (a_j - b_j) mod q_j over a
// two-stage valid/ready pipeline, with per-polynomial framing and a sticky frame error.
module rns_poly_subtractor #(
    parameter int N_SLOTS     = 4,
    parameter int Q_BASIS_LEN = 2,
    parameter int COEF_W      = 8,
    parameter logic [Q_BASIS_LEN-1:0][COEF_W-1:0] Q_MOD = {8'd97, 8'd17}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [Q_BASIS_LEN*COEF_W-1:0] in_a,
    input  logic [Q_BASIS_LEN*COEF_W-1:0] in_b,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [Q_BASIS_LEN*COEF_W-1:0] out_d,
    output logic                          out_last,
    output logic                          err_frame
);

    localparam int DIFF_W = COEF_W + 1;
    localparam int CNT_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SLOTS - 1);

    logic                                s1_valid_q;
    logic [Q_BASIS_LEN-1:0][DIFF_W-1:0]  s1_diff_q;
    logic [Q_BASIS_LEN-1:0][DIFF_W-1:0]  s1_diff_d;

    logic                                s2_valid_q;
    logic [Q_BASIS_LEN*COEF_W-1:0]       s2_res_q;
    logic [Q_BASIS_LEN*COEF_W-1:0]       s2_res_d;

    logic [CNT_W-1:0]                    in_cnt_q;
    logic [CNT_W-1:0]                    in_cnt_d;
    logic [CNT_W-1:0]                    out_cnt_q;
    logic [CNT_W-1:0]                    out_cnt_d;
    logic                                err_frame_q;
    logic                                err_frame_d;

    logic                                s1_adv;
    logic                                s2_adv;
    logic                                in_xfer;
    logic                                out_xfer;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign in_xfer  = in_valid && s1_adv;
    assign out_xfer = s2_valid_q && out_ready;

    // Zero-extended subtraction; the extra MSB is the borrow for stage 2.
    always_comb begin
        s1_diff_d = '0;
        for (int j = 0; j < Q_BASIS_LEN; j++) begin
            s1_diff_d[j] = {1'b0, in_a[j*COEF_W +: COEF_W]}
                         - {1'b0, in_b[j*COEF_W +: COEF_W]};
        end
    end

    // A borrow means the low bits hold a - b + 2^W; adding q_j and truncating
    // yields a - b + q_j, which lies in range for reduced operands.
    always_comb begin
        s2_res_d = '0;
        for (int j = 0; j < Q_BASIS_LEN; j++) begin
            if (s1_diff_q[j][COEF_W]) begin
                s2_res_d[j*COEF_W +: COEF_W] = s1_diff_q[j][COEF_W-1:0] + Q_MOD[j];
            end else begin
                s2_res_d[j*COEF_W +: COEF_W] = s1_diff_q[j][COEF_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_diff_q <= s1_diff_d;
            end
        end
    end

    // Stage 2 only loads when it can advance, so out_d holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q <= s2_res_d;
            end
        end
    end

    // Frame counters wrap on their own count; in_last is only audited.
    always_comb begin
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        err_frame_d = err_frame_q;
        if (in_xfer) begin
            in_cnt_d = (in_cnt_q == LAST_IDX) ? '0 : in_cnt_q + 1'b1;
            if (in_last != (in_cnt_q == LAST_IDX)) begin
                err_frame_d = 1'b1;
            end
        end
        if (out_xfer) begin
            out_cnt_d = (out_cnt_q == LAST_IDX) ? '0 : out_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            err_frame_q <= 1'b0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_d     = s2_res_q;
    assign out_last  = s2_valid_q && (out_cnt_q == LAST_IDX);
    assign err_frame = err_frame_q;

endmodule

// File: tb/tb_rns_poly_subtractor.sv
// Bench for rns_poly_subtractor: a queue-based reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_rns_poly_subtractor;

    localparam int N  = 4;
    localparam int Q0 = 17;
    localparam int Q1 = 97;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_d;
    logic        out_last;
    logic        err_frame;

    rns_poly_subtractor #(
        .N_SLOTS    (N),
        .Q_BASIS_LEN(2),
        .COEF_W     (8),
        .Q_MOD      ({8'd97, 8'd17})
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_d    (out_d),
        .out_last (out_last),
        .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int modsub(input int a, input int b, input int q);
        return (a >= b) ? a - b : a - b + q;
    endfunction

    function automatic logic [15:0] ref_diff(input logic [15:0] a, input logic [15:0] b);
        int r0;
        int r1;
        r0 = modsub(int'(a[7:0]), int'(b[7:0]), Q0);
        r1 = modsub(int'(a[15:8]), int'(b[15:8]), Q1);
        return {r1[7:0], r0[7:0]};
    endfunction

    // Reference model: in-flight beats, frame counters, sticky error.
    logic [15:0] exp_q[$];
    int          m_in_cnt  = 0;
    int          m_out_cnt = 0;
    bit          m_err     = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_d;
    logic        prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_out_valid", out_valid, 0);
            chk("reset_out_d", out_d, 0);
            chk("reset_out_last", out_last, 0);
            chk("reset_err_frame", err_frame, 0);
            exp_q.delete();
            m_in_cnt   = 0;
            m_out_cnt  = 0;
            m_err      = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
            chk("err_frame", err_frame, m_err);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_d, prev_d);
                chk("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected no beat", out_d);
                end else begin
                    chk("out_d", out_d, exp_q.pop_front());
                    chk("out_last", out_last, m_out_cnt == N - 1);
                    m_out_cnt = (m_out_cnt + 1) % N;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_diff(in_a, in_b));
                if (in_last != (m_in_cnt == N - 1)) m_err = 1'b1;
                m_in_cnt = (m_in_cnt + 1) % N;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_d;
            prev_last  = out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        in_valid = 1'b0;
        chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) return;
            step();
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    // One beat into an empty pipe with out_ready=1; checks the exact latency.
    task automatic single(input logic [15:0] a, input logic [15:0] b, input logic last,
                          input logic [15:0] exp, input logic exp_last);
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        chk("single_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat2_valid", out_valid, 1);
        chk("lat2_data", out_d, exp);
        chk("lat2_last", out_last, exp_last);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          n_out;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // a=(5,90) b=(9,3) -> (13,87); boundaries complete a 4-beat frame
        single(16'h5A05, 16'h0309, 1'b0, 16'h570D, 1'b0);
        single(16'h6010, 16'h6010, 1'b0, 16'h0000, 1'b0);
        single(16'h0000, 16'h6010, 1'b0, 16'h0101, 1'b0);
        single(16'h6010, 16'h0000, 1'b1, 16'h6010, 1'b1);

        // Random reduced beats under random backpressure, last on beats 3 and 7
        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = {8'($urandom_range(0, 96)), 8'($urandom_range(0, 16))};
            rb = {8'($urandom_range(0, 96)), 8'($urandom_range(0, 16))};
            send(ra, rb, (i % 4) == 3);
        end
        drain();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("framing_ok_err", err_frame, 0);
        @(posedge clk);
        #1;

        // Full-rate streaming for 100 beats
        n_out = 0;
        for (int i = 0; i < 104; i++) begin
            in_valid = (i < 100);
            in_a     = {8'($urandom_range(0, 96)), 8'($urandom_range(0, 16))};
            in_b     = {8'($urandom_range(0, 96)), 8'($urandom_range(0, 16))};
            in_last  = (i % 4) == 3;
            @(negedge clk);
            if (out_valid && out_ready) n_out++;
            if (i >= 2 && i < 102) chk("fullrate_no_bubble", out_valid, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("fullrate_count", n_out, 100);

        // Misplaced last on beat index 2
        send(16'h0102, 16'h0101, 1'b0);
        send(16'h0102, 16'h0101, 1'b0);
        send(16'h0102, 16'h0101, 1'b1);
        @(negedge clk);
        chk("err_set", err_frame, 1);
        @(posedge clk);
        #1;
        send(16'h0102, 16'h0101, 1'b1);
        drain();
        repeat (3) step();
        chk("err_sticky", err_frame, 1);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(16'h0405, 16'h0203, 1'b0);
        send(16'h0405, 16'h0203, 1'b0);
        chk("pre_reset_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_data", out_d, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("err_cleared", err_frame, 0);
        chk("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;
        // (3,50)-(1,60) -> (2,87)
        for (int i = 0; i < 4; i++) begin
            single(16'h3203, 16'h3C01, i == 3, 16'h5702, i == 3);
        end

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
